// File: rtl/pc_pkg.sv
// pc_pkg: next-PC mode encodings and the sequential PC step shared by the PC unit.
package pc_pkg;
    typedef enum logic [2:0] {
        PS_HOLD = 3'b000,
        PS_INC  = 3'b001,
        PS_BR   = 3'b010,
        PS_JR   = 3'b011,
        PS_CALL = 3'b100,
        PS_RET  = 3'b101
    } ps_e;
    localparam int unsigned INC_STEP = 4;
endpackage

// File: rtl/return_stack.sv
// return_stack: circular return-address stack; a push when full overwrites the oldest entry.
module return_stack #(
    parameter int WIDTH     = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(RAS_DEPTH);
    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_pop;
    assign empty  = cnt_q == '0;
    assign full   = cnt_q == (AW+1)'(RAS_DEPTH);
    assign rdata  = mem_q[ptr_q - AW'(1)];
    assign do_pop = pop && !empty;
    // ptr_q points at the next free slot; when full that is also the oldest entry
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + AW'(1);
            cnt_d = full ? cnt_q : cnt_q + (AW+1)'(1);
        end else if (do_pop) begin
            ptr_d = ptr_q - AW'(1);
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clock) begin
        if (reset && push) mem_q[ptr_q] <= wdata;
    end
endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: program counter with next-PC mode mux and a return-address stack for CALL/RET.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 64,
    parameter int               RAS_DEPTH    = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       PS,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow
);
    logic [WIDTH-1:0] pc_q, pc_d, br_tgt, top;
    logic             uf_q, uf_d, push, pop;
    assign PC            = pc_q;
    assign PC4           = pc_q + WIDTH'(INC_STEP);
    assign br_tgt        = PC4 + {in[WIDTH-3:0], 2'b00};
    assign ras_underflow = uf_q;
    always_comb begin
        pc_d = pc_q;
        push = 1'b0;
        pop  = 1'b0;
        uf_d = 1'b0;
        if (!stall) begin
            case (ps_e'(PS))
                PS_INC:  pc_d = PC4;
                PS_BR:   pc_d = br_tgt;
                PS_JR:   pc_d = in;
                PS_CALL: begin
                    pc_d = br_tgt;
                    push = 1'b1;
                end
                PS_RET:  begin
                    pc_d = ras_empty ? PC4 : top;
                    pop  = !ras_empty;
                    uf_d = ras_empty;
                end
                default: pc_d = pc_q;
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VECTOR;
            uf_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            uf_q <= uf_d;
        end
    end
    return_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (PC4),
        .rdata (top),
        .empty (ras_empty),
        .full  (ras_full)
    );
endmodule

// File: doc/pc_unit_ras.md
PC_UNIT_RAS -- requirements
Module: pc_unit_ras

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the address width.
REQ-002 The module SHALL have parameter RAS_DEPTH, default 8, giving the return-address-stack entry count (power of two, >=2).
REQ-003 The module SHALL have parameter RESET_VECTOR, default 0, giving the PC value loaded on reset.
REQ-004 The module SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port stall, input, 1 bit: when 1, PC and stack hold.
REQ-007 The module SHALL have port PS, input, 3 bits: next-PC mode select.
REQ-008 The module SHALL have port in, input, WIDTH bits: branch word offset (two's complement) or absolute jump target.
REQ-009 The module SHALL have port PC, output, WIDTH bits: current PC register.
REQ-010 The module SHALL have port PC4, output, WIDTH bits: PC+4, combinational.
REQ-011 The module SHALL have port ras_empty, output, 1 bit: stack count is 0.
REQ-012 The module SHALL have port ras_full, output, 1 bit: stack count equals RAS_DEPTH.
REQ-013 The module SHALL have port ras_underflow, output, 1 bit: registered one-cycle pulse on a pop from an empty stack.

Function
REQ-014 PC4 SHALL equal PC+4 modulo 2^WIDTH at all times.
REQ-015 Modes: 000 HOLD, 001 INC, 010 BR, 011 JR, 100 CALL, 101 RET. Codes 110 and 111 SHALL act as HOLD.
REQ-016 HOLD SHALL keep PC unchanged.
REQ-017 INC SHALL load PC4.
REQ-018 BR SHALL load PC4 + {in[WIDTH-3:0],2'b00}, modulo 2^WIDTH.
REQ-019 JR SHALL load in unchanged.
REQ-020 CALL SHALL load the BR target and push PC4 onto the stack in the same edge.
REQ-021 RET SHALL load the top-of-stack value and pop the stack, when the stack is non-empty.
REQ-022 A RET with an empty stack SHALL load PC4, leave the stack unchanged, and assert ras_underflow for exactly the next cycle.
REQ-023 A CALL with a full stack SHALL overwrite the oldest entry (circular) and leave the count at RAS_DEPTH.
REQ-024 Stack pointer wrap-around SHALL be modulo RAS_DEPTH.
REQ-025 With stall=1, no PC, stack, count or pointer change SHALL occur regardless of PS, and ras_underflow SHALL be 0 next cycle.
REQ-026 Latency: the PC update SHALL be visible one cycle after the mode is sampled. A RET issued on the cycle after a CALL SHALL return that CALL's PC4.
REQ-027 ras_empty and ras_full SHALL be decoded combinationally from the registered count.

Reset
REQ-028 While reset=0: PC=RESET_VECTOR, count=0, pointer=0, ras_underflow=0, ras_empty=1, ras_full=0.
REQ-029 Reset mid-operation SHALL abort any pending push or pop with no partial update. Stack storage contents need not be cleared.
REQ-030 The first edge after reset release SHALL apply PS normally.

Structure
REQ-031 Mode encodings SHALL live in shared package pc_pkg as a 3-bit typedef/constants, alongside the INC step constant (4).
REQ-032 The stack SHALL be a sub-module return_stack with ports clock, reset, push, pop, wdata, rdata, empty, full, parameterised by WIDTH and RAS_DEPTH.
REQ-033 pc_unit_ras SHALL contain the PC register, next-PC mux, adders and underflow flop only.

Verification
REQ-034 Reset, then INC x3 -> PC = 0x0, 0x4, 0x8, 0xC on successive cycles; PC4 = 0x10.
REQ-035 PC=0x100, BR with in=-2 (all ones except 0b10) -> PC=0xFC. JR with in=0x2000 -> PC=0x2000.
REQ-036 PC=0x40, CALL in=0x10 -> PC=0x84, ras_empty=0. Then RET -> PC=0x44, ras_empty=1.
REQ-037 Nine CALLs with RAS_DEPTH=8 -> ras_full=1. Eight RETs return the last 8 PC4 values in LIFO order. A ninth RET -> PC=PC4, ras_underflow pulses for 1 cycle.
REQ-038 stall=1 with PS=CALL for 3 cycles -> PC and count unchanged. Deassert stall -> a single push occurs.
REQ-039 Assert reset mid-CALL with count=3 -> PC=RESET_VECTOR, count=0 immediately, asynchronously, without waiting for a clock edge.
